// File: rtl/snow64_main_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : snow64_main_mem_initiator
// Purpose  : Arbitrates two clients (port 0 instruction fetch, read-only;
//            port 1 data/LAR line traffic, read/write) onto a single-port
//            main memory with one-cycle registered read latency.
// Revision : 1.0 - initial release
// ============================================================================
module snow64_main_mem_initiator #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // Port 0: instruction fetch, read-only
    input  logic                  in_req0,
    input  logic [ADDR_WIDTH-1:0] in_req0_addr,

    // Port 1: data line traffic, read or write
    input  logic                  in_req1,
    input  logic                  in_req1_wr,
    input  logic [ADDR_WIDTH-1:0] in_req1_addr,
    input  logic [DATA_WIDTH-1:0] in_req1_data,

    // Client responses
    output logic                  out_ack0,
    output logic                  out_ack1,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_busy,

    // Memory side
    output logic                  out_mem_req_wr,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [DATA_WIDTH-1:0] out_mem_data,
    input  logic [DATA_WIDTH-1:0] in_mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_last_grant;   // port granted most recently (1 after reset so port 0 wins first)
    logic   r_port;         // port owning the access in flight
    logic   r_wr;           // access in flight is a write

    logic   w_any_req;
    logic   w_grant1;
    logic   w_grant_wr;

    // Round-robin pick: port 1 wins when alone, or when both ask and port 0 went last
    assign w_any_req  = in_req0 | in_req1;
    assign w_grant1   = in_req1 & (~in_req0 | ~r_last_grant);
    assign w_grant_wr = w_grant1 & in_req1_wr;

    // Access sequencer: grant in IDLE, present to memory in ISSUE, capture in WAIT, ack in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= 1'b1;
            r_port         <= 1'b0;
            r_wr           <= 1'b0;
            out_ack0       <= 1'b0;
            out_ack1       <= 1'b0;
            out_rdata      <= '0;
            out_busy       <= 1'b0;
            out_mem_req_wr <= 1'b0;
            out_mem_addr   <= '0;
            out_mem_data   <= '0;
        end else begin
            // Acks are single-cycle pulses; only the transition into RESP raises one
            out_ack0 <= 1'b0;
            out_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ST_ISSUE;
                        out_busy     <= 1'b1;
                        r_port       <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_wr         <= w_grant_wr;
                        out_mem_addr <= w_grant1 ? in_req1_addr : in_req0_addr;
                        if (w_grant_wr) begin
                            out_mem_data   <= in_req1_data;
                            out_mem_req_wr <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Memory samples address/strobe at this edge; strobe lasts one cycle
                    out_mem_req_wr <= 1'b0;
                    if (r_wr) begin
                        r_state  <= ST_RESP;
                        out_ack0 <= ~r_port;
                        out_ack1 <= r_port;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    out_rdata <= in_mem_data;
                    r_state   <= ST_RESP;
                    out_ack0  <= ~r_port;
                    out_ack1  <= r_port;
                end
                ST_RESP: begin
                    r_state  <= ST_IDLE;
                    out_busy <= 1'b0;
                end
                default: begin
                    r_state        <= ST_IDLE;
                    out_busy       <= 1'b0;
                    out_mem_req_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snow64_main_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_snow64_main_mem_initiator
// Purpose  : Scoreboard bench for the two-port main memory initiator with a
//            behavioural memory and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snow64_main_mem_initiator;

    localparam int DW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic          req1 = 1'b0;
    logic          req1_wr = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          ack0, ack1, busy, mem_wr;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    snow64_main_mem_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_req0        (req0),
        .in_req0_addr   (req0_addr),
        .in_req1        (req1),
        .in_req1_wr     (req1_wr),
        .in_req1_addr   (req1_addr),
        .in_req1_data   (req1_data),
        .out_ack0       (ack0),
        .out_ack1       (ack1),
        .out_rdata      (rdata),
        .out_busy       (busy),
        .out_mem_req_wr (mem_wr),
        .out_mem_addr   (mem_addr),
        .out_mem_data   (mem_wdata),
        .in_mem_data    (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Power-on contents of a line; line 0 carries the two known instructions
    function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) v = {{6{32'h1357_0000}}, 32'h0000_e001, 32'h0f00_e000};
        else        v = {8{a + 32'h1357_0000}};
        return v;
    endfunction

    // Physical memory seen by the DUT
    logic [DW-1:0] pmem [logic [AW-1:0]];
    function automatic logic [DW-1:0] pmem_rd(input logic [AW-1:0] a);
        return pmem.exists(a) ? pmem[a] : init_line(a);
    endfunction

    always @(posedge clk) begin
        logic [DW-1:0] rd;
        rd = pmem_rd(mem_addr);
        if (mem_wr) pmem[mem_addr] = mem_wdata;
        mem_rdata <= rd;
    end

    // Reference model memory, updated in grant order
    logic [DW-1:0] mmem [logic [AW-1:0]];
    function automatic logic [DW-1:0] mmem_rd(input logic [AW-1:0] a);
        return mmem.exists(a) ? mmem[a] : init_line(a);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int            port;
        bit            wr;
        int            ack_cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    int            m_cnt        = 0;    // cycles remaining until the controller is idle again
    int            m_last       = 1;
    int            m_strobe_cyc = -1;
    logic [DW-1:0] m_rdata      = '0;
    logic [AW-1:0] m_addr       = '0;
    logic [DW-1:0] m_wdata      = '0;

    // Monitor + reference model: compare what the DUT shows, then predict from the inputs it will sample
    always @(negedge clk) begin
        exp_t e;
        int   p;
        bit   w;
        logic [AW-1:0] a;

        chk("ack_exclusive", ack0 & ack1, 0);
        if (ack0 || ack1) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {ack1, ack0}, 0);
            end else begin
                e = q.pop_front();
                chk("ack_port", ack1 ? 1 : 0, e.port);
                chk("ack_cycle", cyc, e.ack_cyc);
                if (!e.wr) m_rdata = e.data;
            end
        end else if (q.size() > 0 && q[0].ack_cyc <= cyc) begin
            e = q.pop_front();
            chk("missing_ack", {ack1, ack0}, 1 << e.port);
        end
        chk("rdata", rdata, m_rdata);
        chk("busy", busy, (m_cnt != 0) ? 1 : 0);
        chk("mem_wr_strobe", mem_wr, (cyc == m_strobe_cyc) ? 1 : 0);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);

        if (rst) begin
            q.delete();
            m_cnt = 0; m_last = 1; m_strobe_cyc = -1;
            m_rdata = '0; m_addr = '0; m_wdata = '0;
        end else if (m_cnt == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) p = (m_last == 0) ? 1 : 0;
                else              p = req1 ? 1 : 0;
                m_last = p;
                w = (p == 1) && req1_wr;
                a = (p == 1) ? req1_addr : req0_addr;
                m_addr = a;
                e.port = p;
                e.wr   = w;
                if (w) begin
                    m_wdata      = req1_data;
                    mmem[a]      = req1_data;
                    m_strobe_cyc = cyc + 1;
                    e.ack_cyc    = cyc + 2;
                    e.data       = '0;
                    m_cnt        = 2;
                end else begin
                    e.ack_cyc = cyc + 3;
                    e.data    = mmem_rd(a);
                    m_cnt     = 3;
                end
                q.push_back(e);
            end
        end else begin
            m_cnt--;
        end
    end

    // Wait (bounded) for an ack on a port, then step into the following IDLE cycle
    task automatic wait_ack(input int port);
        bit got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = (port == 1) ? ack1 : ack0;
        end
        chk("ack_wait", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic rand_client(input int port, input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            int r;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                if (port == 1) req1 = 1'b0; else req0 = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            r = $urandom_range(0, 9);
            if (port == 1) begin
                req1      = 1'b1;
                req1_wr   = $urandom_range(0, 1) == 1;
                req1_addr = (r < 8) ? r : 32'h80;
                req1_data = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            end else begin
                req0      = 1'b1;
                req0_addr = (r < 8) ? r : 32'h80;
            end
            wait_ack(port);
        end
        if (port == 1) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] fin_addr;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Port 0 read of line 0
        req0 = 1'b1; req0_addr = 32'h0;
        wait_ack(0);
        req0 = 1'b0;
        chk("line0_low64", rdata[63:0], 64'h0000_e001_0f00_e000);

        // Port 1 write then read back of line 0x80
        req1 = 1'b1; req1_wr = 1'b1; req1_addr = 32'h80;
        req1_data = {{7{32'h0bad_f00d}}, 32'hdead_beef};
        wait_ack(1);
        req1_wr = 1'b0;
        wait_ack(1);
        req1 = 1'b0;
        chk("line80_low32", rdata[31:0], 32'hdead_beef);

        // Contention: both rise together, then keep presenting new requests
        repeat (2) begin @(posedge clk); #1; end
        req0 = 1'b1; req0_addr = 32'h10;
        req1 = 1'b1; req1_wr = 1'b0; req1_addr = 32'h20;
        fork
            begin wait_ack(0); req0_addr = 32'h11; wait_ack(0); req0 = 1'b0; end
            begin wait_ack(1); req1_addr = 32'h21; wait_ack(1); req1 = 1'b0; end
        join

        // Held request re-issues the same read
        req0 = 1'b1; req0_addr = 32'h5;
        wait_ack(0);
        wait_ack(0);
        req0 = 1'b0;

        // Reset asserted while the read is in WAIT
        @(posedge clk); #1;
        req0 = 1'b1; req0_addr = 32'h3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_rdata", rdata, 0);
        req0 = 1'b1;
        wait_ack(0);
        req0 = 1'b0;

        // Back-to-back port 1 reads: strobe must stay low
        req1 = 1'b1; req1_wr = 1'b0; req1_addr = 32'h6;
        wait_ack(1);
        req1_addr = 32'h7;
        wait_ack(1);
        req1_addr = 32'h80;
        wait_ack(1);
        req1 = 1'b0;

        // Randomised concurrent traffic
        fork
            rand_client(0, 20);
            rand_client(1, 20);
        join

        repeat (8) begin @(posedge clk); #1; end
        chk("pending_acks", q.size(), 0);
        for (int i = 0; i < 9; i++) begin
            fin_addr = (i < 8) ? i : 32'h80;
            chk("final_mem", pmem_rd(fin_addr), mmem_rd(fin_addr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
